// File: rtl/dm_bus_responder_if.sv
// Initiator-to-responder data-memory bus: request fields, read data, one-cycle acknowledge and level irq.
interface dm_bus_responder_if;
    logic [17:0] address;
    logic        bus_enable;
    logic [3:0]  byte_enable;
    logic        rw;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        acknowledge;
    logic        irq;

    modport master (
        output address, bus_enable, byte_enable, rw, write_data,
        input  read_data, acknowledge, irq
    );

    modport slave (
        input  address, bus_enable, byte_enable, rw, write_data,
        output read_data, acknowledge, irq
    );
endinterface

// File: rtl/dm_bus_responder.sv
// Data-memory bus responder: word RAM plus STATUS / ACCESS_CNT registers, one access per bus_enable assertion.
// Optional irq path (doorbell -> irq_pending -> dm_bus.irq, STATUS live) enabled by defining DM_RESP_IRQ_EN.
module dm_bus_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] OOR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_bus_responder_if.slave    dm_bus,
    input  logic                 doorbell
);

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WORDS     = 2 ** DEPTH_LOG2;
    localparam int unsigned MEM_BYTES = 4 * WORDS;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 18'h3FFF0;
    localparam logic [ADDR_W-1:0] CNT_ADDR    = 18'h3FFF4;

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, RELEASE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    wr_en;
    logic                    rd_en;
    logic                    rd_load;
    logic                    ack_nxt;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       mem_q;
    logic [DATA_W-1:0]       rd_mux;
    logic [DATA_W-1:0]       access_cnt;
    logic                    irq_pending;
    logic                    live_mem;
    logic                    q_mem;
    logic                    q_status;
    logic                    q_cnt;
    logic [DEPTH_LOG2-1:0]   live_idx;
    logic [DATA_W-1:0]       mem [WORDS];

    assign live_mem = 32'(dm_bus.address) < MEM_BYTES;
    assign live_idx = dm_bus.address[DEPTH_LOG2+1:2];
    assign q_mem    = 32'(addr_q) < MEM_BYTES;
    assign q_status = {addr_q[ADDR_W-1:2], 2'b00} == STATUS_ADDR;
    assign q_cnt    = {addr_q[ADDR_W-1:2], 2'b00} == CNT_ADDR;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dm_bus.bus_enable) state_nxt = dm_bus.rw ? RD_WAIT : ACK;
            RD_WAIT: state_nxt = ACK;
            ACK:     state_nxt = RELEASE;
            RELEASE: if (!dm_bus.bus_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_load = 1'b0;
        ack_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (dm_bus.bus_enable) begin
                    wr_en   = !dm_bus.rw;
                    rd_en   = dm_bus.rw;
                    ack_nxt = !dm_bus.rw;
                end
            end
            RD_WAIT: begin
                rd_load = 1'b1;
                ack_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM: writes commit in the request cycle; reads present the address in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en && live_mem && !reset) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (dm_bus.byte_enable[b]) mem[live_idx][8*b +: 8] <= dm_bus.write_data[8*b +: 8];
            end
        end
        if (rd_en && live_mem) mem_q <= mem[live_idx];
    end

    always_comb begin
        rd_mux = OOR_DATA;
        if (q_mem)         rd_mux = mem_q;
        else if (q_status) rd_mux = {31'b0, irq_pending};
        else if (q_cnt)    rd_mux = access_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dm_bus.acknowledge <= 1'b0;
            dm_bus.read_data   <= '0;
            access_cnt         <= '0;
            addr_q             <= '0;
        end else begin
            dm_bus.acknowledge <= ack_nxt;
            if (rd_load)            dm_bus.read_data <= rd_mux;
            if (dm_bus.acknowledge) access_cnt       <= access_cnt + 32'd1;
            if (wr_en || rd_en)     addr_q           <= dm_bus.address;
        end
    end

`ifdef DM_RESP_IRQ_EN
    logic live_status;
    assign live_status = {dm_bus.address[ADDR_W-1:2], 2'b00} == STATUS_ADDR;

    // Doorbell set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset)
            irq_pending <= 1'b0;
        else if (doorbell)
            irq_pending <= 1'b1;
        else if (wr_en && live_status && dm_bus.byte_enable[0] && dm_bus.write_data[0])
            irq_pending <= 1'b0;
    end
`else
    logic unused_doorbell;
    assign unused_doorbell = doorbell;
    assign irq_pending     = 1'b0;
`endif

    assign dm_bus.irq = irq_pending;

endmodule

// File: doc/dm_bus_responder.md
DM_BUS_RESPONDER -- requirements
Module: dm_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit data-memory words.
REQ-002 SHALL have parameter OOR_DATA, default 32'hDEAD_BEEF, the value returned by an out-of-range read.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port dm_bus_address, input, 18 bits, byte address from the initiator.
REQ-006 SHALL have port dm_bus_bus_enable, input, 1 bit; the initiator holds it high until it sees acknowledge.
REQ-007 SHALL have ports dm_bus_byte_enable (input, 4 bits, write lane mask), dm_bus_rw (input, 1 bit, 1=read, 0=write) and dm_bus_write_data (input, 32 bits).
REQ-008 SHALL have port dm_bus_read_data, output, 32 bits, read result.
REQ-009 SHALL have port dm_bus_acknowledge, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port dm_bus_irq, output, 1 bit, level interrupt to the initiator.
REQ-011 SHALL have port doorbell, input, 1 bit, a fabric-side single-cycle interrupt request.

Function
REQ-012 SHALL implement a state machine with states IDLE, RD_WAIT, ACK and RELEASE.
REQ-013 In IDLE with bus_enable=1 (cycle T), SHALL capture address, rw, byte_enable and write_data.
- Write: commit at the end of T, go to ACK.
- Read: present the RAM address in T, go to RD_WAIT.
REQ-014 RD_WAIT SHALL register the RAM or register output into dm_bus_read_data and go to ACK.
- Write latency: acknowledge high in T+1.
- Read latency: acknowledge high in T+2, with read_data valid in the same cycle.
REQ-015 ACK SHALL drive acknowledge=1 for exactly one cycle, then go to RELEASE.
REQ-016 RELEASE SHALL stay until bus_enable=0, then go to IDLE; a held bus_enable SHALL never start a second access.
REQ-017 dm_bus_read_data SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-018 Memory region:
- Word index is address[DEPTH_LOG2+1:2], valid when address < 4*2^DEPTH_LOG2.
- address[1:0] is ignored.
REQ-019 Writes SHALL update only the byte lanes whose byte_enable bit is 1; byte_enable=0 SHALL leave memory unchanged but still acknowledge.
REQ-020 Control registers:
- 0x3FFF0 STATUS: bit0 irq_pending; writing 1 to bit0 clears it.
- 0x3FFF4 ACCESS_CNT: read-only, 32 bits.
REQ-021 Any other out-of-range address: reads SHALL return OOR_DATA, writes SHALL be discarded, and both SHALL still acknowledge.
REQ-022 ACCESS_CNT SHALL increment on every acknowledge, wrapping from 0xFFFFFFFF to 0.
REQ-023 doorbell=1 SHALL set irq_pending; if set and clear occur in the same cycle, set SHALL win.
REQ-024 dm_bus_irq SHALL equal irq_pending.

Reset
REQ-025 Reset SHALL force: state=IDLE, acknowledge=0, read_data=0, irq_pending=0, ACCESS_CNT=0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-transaction SHALL abort it with no acknowledge; an aborted write that committed before reset SHALL remain committed.
REQ-028 After reset, bus_enable still high SHALL be treated as a new request.

Configuration
REQ-029 Macro DM_RESP_IRQ_EN SHALL gate the irq feature.
- Defined: REQ-023/024 apply and STATUS is live.
- Undefined: doorbell is ignored, dm_bus_irq is tied 0, and STATUS reads 0 with writes discarded.

Verification
REQ-030 Write 0x00000010 <- 0xA5A5A5A5 (be=0xF), then read -> acknowledge at T+1 for the write, then read_data 0xA5A5A5A5 with acknowledge at T+2.
REQ-031 Write 0x10 <- 0x11223344 with be=0b0101 over 0xA5A5A5A5 -> read returns 0xA522A544.
REQ-032 Hold bus_enable high 5 cycles after acknowledge -> exactly one acknowledge and ACCESS_CNT +1.
REQ-033 Read 0x20000 -> 0xDEADBEEF and acknowledge; then read 0x3FFF4 after 3 prior accesses -> 0x00000003.
REQ-034 doorbell pulse -> irq=1; write 0x1 to 0x3FFF0 in the same cycle as a doorbell -> irq stays 1; next clear -> irq=0.
REQ-035 Assert reset in RD_WAIT -> no acknowledge, read_data=0, state IDLE next cycle.
